// File: rtl/muxf_tree_pipe.sv
// N:1 cascaded 2:1 mux tree with per-level pipeline registers, CE and valid.
// Define MUXF_TREE_HOLD_EN to load stage data/select only on valid samples.
module muxf_tree_pipe #(
  parameter int unsigned            WIDTH     = 1,
  parameter int unsigned            SEL_W     = 3,
  parameter logic [SEL_W-1:0]       LEVEL_REG = SEL_W'(4)
) (
  input  logic                      C,
  input  logic                      CLR_N,
  input  logic                      CE,
  input  logic                      VI,
  input  logic [WIDTH*(1<<SEL_W)-1:0] I,
  input  logic [SEL_W-1:0]          S,
  output logic                      VO,
  output logic [WIDTH-1:0]          O
);

  localparam int N  = 1 << SEL_W;
  localparam int DW = WIDTH * (2 * N - 1);
  localparam int SW = SEL_W * (SEL_W + 1) / 2;

  // Boundary k data/select live packed back to back in dat/sel.
  function automatic int doff(input int k);
    return WIDTH * (2 * N - 2 * (N >> k));
  endfunction

  function automatic int soff(input int k);
    return k * SEL_W - (k * (k - 1)) / 2;
  endfunction

  logic [DW-1:0]  dat;
  logic [SW-1:0]  sel;
  logic [SEL_W:0] vld;

  assign dat[WIDTH*N-1:0] = I;
  assign sel[SEL_W-1:0]   = S;
  assign vld[0]           = VI;

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int NO  = N >> (k + 1);
    localparam int DI  = doff(k);
    localparam int DO  = doff(k + 1);
    localparam int SI  = soff(k);
    localparam int SO  = soff(k + 1);
    localparam int SWO = SEL_W - k - 1;

    logic [WIDTH*NO-1:0] mux_d;

    always_comb begin
      mux_d = '0;
      for (int m = 0; m < NO; m++) begin
        mux_d[m*WIDTH +: WIDTH] = sel[SI]
          ? dat[DI + (2*m+1)*WIDTH +: WIDTH]
          : dat[DI + (2*m)*WIDTH +: WIDTH];
      end
    end

    if (LEVEL_REG[k]) begin : g_reg
      logic                ld;
      logic [WIDTH*NO-1:0] dat_d, dat_q;
      logic                vld_d, vld_q;

`ifdef MUXF_TREE_HOLD_EN
      assign ld = CE & vld[k];
`else
      assign ld = CE;
`endif

      always_comb begin
        dat_d = ld ? mux_d : dat_q;
        vld_d = CE ? vld[k] : vld_q;
      end

      always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
          dat_q <= '0;
          vld_q <= 1'b0;
        end else begin
          dat_q <= dat_d;
          vld_q <= vld_d;
        end
      end

      assign dat[DO +: WIDTH*NO] = dat_q;
      assign vld[k+1]            = vld_q;

      // Remaining select bits travel with their data.
      if (SWO > 0) begin : g_sel
        logic [SWO-1:0] sel_d, sel_q;

        always_comb begin
          sel_d = ld ? sel[SI+1 +: SWO] : sel_q;
        end

        always_ff @(posedge C or negedge CLR_N) begin
          if (!CLR_N) begin
            sel_q <= '0;
          end else begin
            sel_q <= sel_d;
          end
        end

        assign sel[SO +: SWO] = sel_q;
      end
    end else begin : g_comb
      assign dat[DO +: WIDTH*NO] = mux_d;
      assign vld[k+1]            = vld[k];
      if (SWO > 0) begin : g_sel
        assign sel[SO +: SWO] = sel[SI+1 +: SWO];
      end
    end
  end

  if (LEVEL_REG == '0) begin : g_noreg
    logic unused_ctl;
    assign unused_ctl = ^{C, CLR_N, CE};
  end

  assign O  = dat[DW-1 -: WIDTH];
  assign VO = vld[SEL_W];

endmodule
